oled_seq_arbiter: RTL and testbench

Parametrised OLED phase sequencer and IIC-word arbiter: the next-generation replacement for the fixed init/refresh/font/data state machine in the OLED display path. It runs a configurable number of boot-phase clients once, in order, after reset. It then serves triggered runtime clients, such as sensor data pages, by round-robin arbitration, and latches triggers that arrive while busy so updates are never lost. It muxes the granted client's 24-bit IIC word onto a single IIC_Driver write port and guards each transfer with a watchdog.

---
 rtl/oled_seq_arbiter_if.sv | 29 ++
 rtl/oled_seq_arbiter.sv | 151 +++++++++++++++
 tb/tb_oled_seq_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_seq_arbiter_if.sv
// rtl/oled_seq_arbiter_if.sv - client, IIC-write and status bundle for the OLED phase sequencer
interface oled_seq_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 24
);
  logic [NUM_CH-1:0]    trig;
  logic [NUM_CH-1:0]    ch_grant;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*DW-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_finish;
  logic [NUM_CH-1:0]    ch_ack;
  logic                 iic_req;
  logic [DW-1:0]        iic_data;
  logic                 iic_done;
  logic                 boot_done;
  logic                 busy;
  logic [NUM_CH-1:0]    pending;
  logic                 timeout_err;

  modport slave (
    input  trig, ch_valid, ch_data, ch_finish, iic_done,
    output ch_grant, ch_ack, iic_req, iic_data, boot_done, busy, pending, timeout_err
  );

  modport master (
    output trig, ch_valid, ch_data, ch_finish, iic_done,
    input  ch_grant, ch_ack, iic_req, iic_data, boot_done, busy, pending, timeout_err
  );
endinterface

// File: rtl/oled_seq_arbiter.sv
// rtl/oled_seq_arbiter.sv - boot-phase sequencer and round-robin IIC-word arbiter for the OLED path
module oled_seq_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int BOOT_CH     = 3,
  parameter int DW          = 24,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  oled_seq_arbiter_if.slave bus
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [NUM_CH-1:0] RT_MASK = ~NUM_CH'((1 << BOOT_CH) - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     boot_idx_q, boot_idx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              boot_done_q, boot_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic [WW-1:0]     wdog_q, wdog_d;

  logic [NUM_CH-1:0] live;
  logic [NUM_CH-1:0] clr;
  logic [DW-1:0]     mux_data;
  logic              req;
  logic              finish_g;
  logic              abort;
  logic [PW-1:0]     win;
  logic              win_vld;
  int                best;

  // Grant is one-hot, so OR-ing the live slices selects the granted word.
  always_comb begin
    live     = grant_q & bus.ch_valid;
    mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (live[i]) mux_data = mux_data | bus.ch_data[i*DW +: DW];
    end
  end

  assign req      = |live;
  assign finish_g = |(grant_q & bus.ch_finish);
  // A word that completes or a phase that finishes on the deadline cycle is not an error.
  assign abort    = (TIMEOUT_CYC != 0) && req && !bus.iic_done && !finish_g &&
                    (wdog_q == WW'(TIMEOUT_CYC));

  // Winner is the pending bit at the smallest upward distance from ptr+1.
  always_comb begin
    win     = ptr_q;
    best    = NUM_CH;
    win_vld = |pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pending_q[i] && (((i - int'(ptr_q) - 1 + NUM_CH) % NUM_CH) < best)) begin
        best = (i - int'(ptr_q) - 1 + NUM_CH) % NUM_CH;
        win  = PW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    boot_idx_d    = boot_idx_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    boot_done_d   = boot_done_q;
    timeout_err_d = timeout_err_q | abort;
    clr           = '0;

    unique case (state_q)
      ST_BOOT: begin
        grant_d = NUM_CH'(1) << boot_idx_q;
        if (finish_g || abort) begin
          if (int'(boot_idx_q) < BOOT_CH - 1) begin
            boot_idx_d = boot_idx_q + 1'b1;
            grant_d    = NUM_CH'(1) << (boot_idx_q + 1'b1);
          end else begin
            grant_d     = '0;
            boot_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          grant_d = NUM_CH'(1) << win;
          clr     = grant_d;
          ptr_d   = win;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (finish_g || abort) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_BOOT;
      end
    endcase

    // A trigger landing on the clear cycle wins, so a re-armed channel is not lost.
    pending_d = (pending_q & ~clr) | (bus.trig & RT_MASK);

    if ((TIMEOUT_CYC != 0) && req && !bus.iic_done && (grant_d == grant_q)) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      boot_idx_q    <= '0;
      ptr_q         <= PW'(NUM_CH - 1);
      grant_q       <= '0;
      pending_q     <= '0;
      boot_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      boot_idx_q    <= boot_idx_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      pending_q     <= pending_d;
      boot_done_q   <= boot_done_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
    end
  end

  assign bus.ch_grant    = grant_q;
  assign bus.ch_ack      = grant_q & {NUM_CH{bus.iic_done}};
  assign bus.iic_req     = req;
  assign bus.iic_data    = mux_data;
  assign bus.boot_done   = boot_done_q;
  assign bus.busy        = |grant_q;
  assign bus.pending     = pending_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_oled_seq_arbiter.sv
// tb/tb_oled_seq_arbiter.sv - randomized self-checking bench for oled_seq_arbiter
module tb_oled_seq_arbiter;
  localparam int N  = 6;
  localparam int B  = 3;
  localparam int DW = 24;
  localparam int TO = 16;
  localparam logic [N-1:0] ONE = 1;

  logic sys_clk = 1'b0;
  logic rst_n;

  oled_seq_arbiter_if #(.NUM_CH(N), .DW(DW)) bus ();

  oled_seq_arbiter #(.NUM_CH(N), .BOOT_CH(B), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int            errors = 0;
  int            checks = 0;
  int            nwords[N];
  int            wleft[N];
  int            fin_step[N];
  logic [DW-1:0] word[N];
  logic [N-1:0]  prev_g, last_ack, trig_next;
  bit            hang, noise;
  int            drv_cnt, stepn, drop_step, ack_total, mux_bad;
  int            grant_ch[$];
  int            grant_step[$];
  int            exp_q[$];
  int            m_ptr;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic model_reset();
    prev_g    = '0;
    last_ack  = '0;
    trig_next = '0;
    drv_cnt   = 0;
    m_ptr     = N - 1;
  endtask

  // Expected service order: repeatedly take the next set bit above the pointer, wrapping.
  task automatic model_order(input logic [N-1:0] mask);
    bit set[N];
    for (int i = 0; i < N; i++) set[i] = mask[i] && (i >= B);
    exp_q.delete();
    for (int n = 0; n < N; n++) begin
      int nxt = -1;
      for (int k = 1; k <= N && nxt < 0; k++) begin
        if (set[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
      end
      if (nxt >= 0) begin
        exp_q.push_back(nxt);
        set[nxt] = 1'b0;
        m_ptr    = nxt;
      end
    end
  endtask

  // One clock: client and IIC-driver behaviour, plus a tally of mux disagreements.
  task automatic step();
    logic [N-1:0]    g, v, f, ack;
    logic [N*DW-1:0] d;
    logic [DW-1:0]   expd;
    logic            expr, done;
    @(negedge sys_clk);
    stepn++;
    for (int i = 0; i < N; i++) begin
      if (last_ack[i]) begin
        ack_total++;
        if (wleft[i] > 0) wleft[i]--;
        word[i] = DW'($urandom);
      end
    end
    g = bus.ch_grant;
    for (int i = 0; i < N; i++) begin
      if (g[i] && !prev_g[i]) begin
        grant_ch.push_back(i);
        grant_step.push_back(stepn);
        wleft[i] = nwords[i];
        word[i]  = DW'($urandom);
      end
    end
    if (g == '0 && prev_g != '0) drop_step = stepn;
    prev_g = g;
    expd   = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        v[i] = (wleft[i] > 0);
        f[i] = (wleft[i] == 0);
        if (f[i]) fin_step[i] = stepn;
        d[i*DW +: DW] = word[i];
        if (v[i]) expd = word[i];
      end else begin
        v[i] = noise && ($urandom_range(0, 1) == 1);
        f[i] = noise && ($urandom_range(0, 1) == 1);
        d[i*DW +: DW] = DW'($urandom);
      end
    end
    expr = |(g & v);
    done = 1'b0;
    if (expr && !hang) begin
      if (drv_cnt == 0) begin
        done    = 1'b1;
        drv_cnt = $urandom_range(0, 2);
      end else begin
        drv_cnt--;
      end
    end
    ack = g & {N{done}};
    bus.ch_valid  = v;
    bus.ch_finish = f;
    bus.ch_data   = d;
    bus.iic_done  = done;
    bus.trig      = trig_next;
    trig_next     = '0;
    #1;
    if (bus.iic_req !== expr || bus.iic_data !== expd || bus.ch_ack !== ack ||
        bus.busy !== (g != '0)) mux_bad++;
    last_ack = ack;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (bus.ch_grant == '0 && bus.pending == '0) quiet++;
      else quiet = 0;
      if (quiet >= 3) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.trig      = '0;
    bus.ch_valid  = '0;
    bus.ch_finish = '0;
    bus.ch_data   = '0;
    bus.iic_done  = 1'b0;
    model_reset();
    noise = 1'b1; hang = 1'b0; ack_total = 0; mux_bad = 0; stepn = 0;
    for (int i = 0; i < N; i++) nwords[i] = $urandom_range(1, 3);
    nwords[0] = 2;
    repeat (3) @(negedge sys_clk);
    #1;
    checks++; if (bus.ch_grant !== '0) $display("FAIL reset_grant: got %b want 0", bus.ch_grant);
    if (bus.ch_grant !== '0) errors++;
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL reset_pending: got %b want 0", bus.pending); end
    checks++; if (bus.boot_done !== 1'b0 || bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got boot_done=%b timeout_err=%b want 0 0", bus.boot_done, bus.timeout_err);
    end
    checks++; if (bus.iic_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_req: got iic_req=%b busy=%b want 0 0", bus.iic_req, bus.busy);
    end
    rst_n = 1'b1;
    step();
    checks++; if (bus.ch_grant !== ONE) begin errors++; $display("FAIL reset_first_grant: got %b want %b", bus.ch_grant, ONE); end
  endtask

  task automatic test_boot();
    int gap = 0;
    bit ok = 1'b0, sent = 1'b0;
    int exp_ack;
    logic [N-1:0] exp_pend;
    mux_bad  = 0;
    exp_ack  = nwords[0] + nwords[1] + nwords[2];
    exp_pend = ONE << 3;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (!sent && bus.ch_grant[1]) begin
        trig_next    = '0;
        trig_next[3] = 1'b1;
        trig_next[1] = 1'b1;
        sent         = 1'b1;
      end
      step();
      if (bus.boot_done) ok = 1'b1;
      else if (bus.ch_grant == '0) gap++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL boot_done: got 0 want 1"); end
    checks++;
    if (grant_ch.size() < 3 || grant_ch[0] != 0 || grant_ch[1] != 1 || grant_ch[2] != 2) begin
      errors++; $display("FAIL boot_order: got %p want 0,1,2", grant_ch);
    end
    checks++; if (gap != 0) begin errors++; $display("FAIL boot_gap: got %0d idle cycles want 0", gap); end
    checks++; if (ack_total != exp_ack) begin errors++; $display("FAIL boot_acks: got %0d want %0d", ack_total, exp_ack); end
    checks++; if (bus.pending !== exp_pend) begin errors++; $display("FAIL boot_pending: got %b want %b", bus.pending, exp_pend); end
    model_order(exp_pend);
    step();
    checks++; if (bus.ch_grant !== exp_pend || stepn - fin_step[2] != 2) begin
      errors++; $display("FAIL boot_to_run: got grant=%b after %0d cycles want %b after 2", bus.ch_grant, stepn - fin_step[2], exp_pend);
    end
    checks++; if (grant_ch[$] != exp_q[0] || bus.pending !== '0) begin
      errors++; $display("FAIL boot_first_rt: got ch%0d pending=%b want ch%0d pending=0", grant_ch[$], bus.pending, exp_q[0]);
    end
    checks++; if (mux_bad != 0) begin errors++; $display("FAIL boot_mux: got %0d bad cycles want 0", mux_bad); end
  endtask

  task automatic test_rearm();
    int base, runs = 0;
    bit ok;
    mux_bad      = 0;
    base         = grant_ch.size() - 1;
    trig_next    = '0;
    trig_next[3] = 1'b1;
    model_order(ONE << 3);
    wait_idle(200, ok);
    for (int i = base; i < grant_ch.size(); i++) if (grant_ch[i] == 3) runs++;
    checks++; if (!ok || runs != 2) begin errors++; $display("FAIL rearm_runs: got %0d runs idle=%0b want 2 runs idle=1", runs, ok); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL rearm_pending: got %b want 0", bus.pending); end
    checks++; if (mux_bad != 0) begin errors++; $display("FAIL rearm_mux: got %0d bad cycles want 0", mux_bad); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] mask;
    int base, t_at;
    bit ok, same;
    mux_bad = 0;
    for (int r = 0; r < 8; r++) begin
      if (r == 0) begin
        mask = '0; mask[3] = 1'b1; mask[5] = 1'b1;
      end else begin
        mask = N'($urandom);
      end
      model_order(mask);
      base      = grant_ch.size();
      trig_next = mask;
      t_at      = stepn + 1;
      wait_idle(300, ok);
      same = ok && (grant_ch.size() - base == exp_q.size());
      for (int i = 0; same && i < exp_q.size(); i++) if (grant_ch[base + i] != exp_q[i]) same = 1'b0;
      checks++; if (!same) begin
        errors++; $display("FAIL rr_order round %0d: got %p want %p", r, grant_ch[base:$], exp_q);
      end
      if (exp_q.size() > 0 && grant_step.size() > base) begin
        checks++; if (grant_step[base] - t_at != 2) begin
          errors++; $display("FAIL rr_latency round %0d: got %0d want 2", r, grant_step[base] - t_at);
        end
      end
    end
    checks++; if (mux_bad != 0) begin errors++; $display("FAIL rr_mux: got %0d bad cycles want 0", mux_bad); end
  endtask

  task automatic test_timeout();
    int req_step = -1, drop = -1, base;
    bit ok;
    mux_bad = 0;
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clean: got %b want 0", bus.timeout_err); end
    hang         = 1'b1;
    nwords[4]    = 1;
    trig_next    = '0;
    trig_next[4] = 1'b1;
    model_order(ONE << 4);
    for (int c = 0; c < 10 && req_step < 0; c++) begin
      step();
      if (bus.iic_req && bus.ch_grant[4]) req_step = stepn;
    end
    trig_next[5] = 1'b1;
    for (int c = 0; c < 40 && drop < 0; c++) begin
      step();
      if (!bus.ch_grant[4]) drop = stepn;
    end
    checks++; if (req_step < 0 || drop - req_step != TO + 1) begin
      errors++; $display("FAIL to_latency: got %0d want %0d", drop - req_step, TO + 1);
    end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", bus.timeout_err); end
    hang = 1'b0;
    base = grant_ch.size();
    model_order(ONE << 5);
    wait_idle(200, ok);
    checks++; if (!ok || grant_ch.size() != base + 1 || grant_ch[$] != exp_q[0]) begin
      errors++; $display("FAIL to_next_served: got last ch%0d idle=%0b want ch%0d idle=1", grant_ch[$], ok, exp_q[0]);
    end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", bus.timeout_err); end
    checks++; if (mux_bad != 0) begin errors++; $display("FAIL to_mux: got %0d bad cycles want 0", mux_bad); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    hang         = 1'b1;
    nwords[3]    = 3;
    trig_next    = '0;
    trig_next[3] = 1'b1;
    trig_next[5] = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (bus.iic_req && bus.ch_grant[3]) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_setup: got no word on ch3 want iic_req=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.iic_req !== 1'b0 || bus.ch_grant !== '0 || bus.ch_ack !== '0) begin
      errors++; $display("FAIL rstmid_async: got req=%b grant=%b ack=%b want 0 0 0", bus.iic_req, bus.ch_grant, bus.ch_ack);
    end
    checks++; if (bus.pending !== '0 || bus.timeout_err !== 1'b0 || bus.boot_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got pending=%b err=%b boot_done=%b want 0 0 0", bus.pending, bus.timeout_err, bus.boot_done);
    end
    hang = 1'b0;
    model_reset();
    @(negedge sys_clk);
    rst_n = 1'b1;
    step();
    checks++; if (bus.ch_grant !== ONE || bus.boot_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_reboot: got grant=%b boot_done=%b want %b 0", bus.ch_grant, bus.boot_done, ONE);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_rearm();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
